// File: rtl/lock_pkg.sv
// Shared state encoding, width helpers and default timing for the parametrised code lock.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_e;

  localparam int LOCKOUT_CYC_DEF = 1000000;
  localparam int RELOCK_CYC_DEF  = 5000000;

  function automatic int dw_f(input int n_btn);
    return (n_btn <= 2) ? 1 : $clog2(n_btn);
  endfunction

  function automatic int cw_f(input int code_len);
    return $clog2(code_len + 1);
  endfunction

  function automatic int fw_f(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

  function automatic int tw_f(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/code_lock_core_if.sv
// Button/command inputs and status outputs of the code lock, bundled for the top-level hookup.
interface code_lock_core_if #(
  parameter int N_BTN    = 4,
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
) ();
  import lock_pkg::*;

  localparam int CW = cw_f(CODE_LEN);
  localparam int FW = fw_f(MAX_FAIL);

  logic [N_BTN-1:0] btn_pulse;
  logic             lock_req;
  logic             prog_en;
  logic             unlocked;
  logic             locked_out;
  logic             prog_active;
  logic [CW-1:0]    entry_cnt;
  logic [FW-1:0]    fail_cnt;
  logic             err_pulse;

  modport master (
    output btn_pulse, lock_req, prog_en,
    input  unlocked, locked_out, prog_active, entry_cnt, fail_cnt, err_pulse
  );

  modport slave (
    input  btn_pulse, lock_req, prog_en,
    output unlocked, locked_out, prog_active, entry_cnt, fail_cnt, err_pulse
  );

endinterface

// File: rtl/lock_timer.sv
// Loadable saturating down-counter shared by the lockout and relock paths.
module lock_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [TW-1:0] cnt_o,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: load wins over decrement, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/code_lock_core.sv
// Code lock core: sequence check with lockout, auto-relock and in-field reprogramming.
module code_lock_core
  import lock_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int RELOCK_CYC  = RELOCK_CYC_DEF,
  parameter logic [CODE_LEN*dw_f(N_BTN)-1:0] DEFAULT_CODE = 8'hE4
) (
  input  logic           clk,
  input  logic           rst_n,
  code_lock_core_if.slave bus
);

  localparam int DW = dw_f(N_BTN);
  localparam int CW = cw_f(CODE_LEN);
  localparam int FW = fw_f(MAX_FAIL);
  localparam int TW = tw_f(LOCKOUT_CYC, RELOCK_CYC);
  localparam int KW = CODE_LEN * DW;

  lock_state_e   state_q, state_d;
  logic [KW-1:0] code_q, code_d, shadow_q, shadow_d, shadow_wr;
  logic [CW-1:0] entry_q, entry_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic          match_q, match_d;
  logic          err_q, err_d;
  logic          unlocked_q, unlocked_d, locked_out_q, locked_out_d, prog_q, prog_d;

  logic          any_press, valid_press, multi_press, digit_ok, entry_last;
  logic [DW-1:0] digit, exp_digit;
  logic          tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic [TW-1:0] tmr_val, tmr_cnt;

  // index encode of the pressed button; only meaningful for a one-hot press
  always_comb begin
    digit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      digit = digit | (bus.btn_pulse[i] ? DW'(i) : '0);
    end
  end

  assign any_press   = |bus.btn_pulse;
  assign valid_press = $onehot(bus.btn_pulse);
  assign multi_press = any_press && !valid_press;
  assign exp_digit   = code_q[int'(entry_q)*DW +: DW];
  assign digit_ok    = valid_press && (digit == exp_digit);
  assign entry_last  = (entry_q == CW'(CODE_LEN - 1));
  assign fail_inc    = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
  assign tmr_last    = tmr_zero || (tmr_cnt == TW'(1));

  // shadow code with the current digit merged at the entry position
  always_comb begin
    shadow_wr = shadow_q;
    shadow_wr[int'(entry_q)*DW +: DW] = digit;
  end

  lock_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  // next-state, counters and timer control
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    entry_d  = entry_q;
    fail_d   = fail_q;
    match_d  = match_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      LOCKED: begin
        // mismatches are only reported after the full sequence, so timing reveals nothing
        if (any_press && entry_last) begin
          entry_d = '0;
          match_d = 1'b1;
          if (match_q && digit_ok) begin
            state_d  = UNLOCKED;
            fail_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(RELOCK_CYC);
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_q >= FW'(MAX_FAIL - 1)) begin
              state_d  = LOCKOUT;
              tmr_load = 1'b1;
              tmr_val  = TW'(LOCKOUT_CYC);
            end else begin
              state_d = LOCKED;
            end
          end
        end else if (any_press) begin
          entry_d = entry_q + CW'(1);
          match_d = match_q && digit_ok;
        end else begin
          state_d = LOCKED;
        end
      end
      LOCKOUT: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          state_d = LOCKED;
          fail_d  = '0;
        end else begin
          state_d = LOCKOUT;
        end
      end
      UNLOCKED: begin
        if (bus.lock_req) begin
          state_d = LOCKED;
          entry_d = '0;
          match_d = 1'b1;
        end else if (bus.prog_en) begin
          state_d = PROGRAM;
          entry_d = '0;
        end else if (any_press) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(RELOCK_CYC);
        end else if (tmr_last) begin
          state_d = LOCKED;
          entry_d = '0;
          match_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PROGRAM: begin
        if (!bus.prog_en || multi_press) begin
          state_d = UNLOCKED;
          entry_d = '0;
          err_d   = 1'b1;
        end else if (valid_press && entry_last) begin
          code_d   = shadow_wr;
          entry_d  = '0;
          state_d  = UNLOCKED;
          tmr_load = 1'b1;
          tmr_val  = TW'(RELOCK_CYC);
        end else if (valid_press) begin
          shadow_d = shadow_wr;
          entry_d  = entry_q + CW'(1);
        end else begin
          state_d = PROGRAM;
        end
      end
      default: begin
        state_d = LOCKED;
        entry_d = '0;
        match_d = 1'b1;
      end
    endcase
    unlocked_d   = (state_d == UNLOCKED) || (state_d == PROGRAM);
    locked_out_d = (state_d == LOCKOUT);
    prog_d       = (state_d == PROGRAM);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOCKED;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
      entry_q      <= '0;
      fail_q       <= '0;
      match_q      <= 1'b1;
      err_q        <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      prog_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      entry_q      <= entry_d;
      fail_q       <= fail_d;
      match_q      <= match_d;
      err_q        <= err_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      prog_q       <= prog_d;
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.prog_active = prog_q;
  assign bus.entry_cnt   = entry_q;
  assign bus.fail_cnt    = fail_q;
  assign bus.err_pulse   = err_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Self-checking bench: directed scenarios plus random stimulus against a queue-based behavioural model.
module tb_code_lock_core;

  localparam int N_BTN    = 4;
  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT  = 16;
  localparam int RELOCK   = 32;

  localparam int M_LOCKED   = 0;
  localparam int M_UNLOCKED = 1;
  localparam int M_PROGRAM  = 2;
  localparam int M_LOCKOUT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pe = 1'b0;

  int checks = 0;
  int errors = 0;

  int mode;
  int attempt[$];
  int pbuf[$];
  int code[CODE_LEN];
  int fails;
  int lock_left;
  int idle_cnt;
  bit err;

  code_lock_core_if #(.N_BTN(N_BTN), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL)) bus ();

  code_lock_core #(
    .N_BTN       (N_BTN),
    .CODE_LEN    (CODE_LEN),
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT_CYC (LOCKOUT),
    .RELOCK_CYC  (RELOCK),
    .DEFAULT_CODE(8'hE4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int btn_digit(input logic [3:0] b);
    int d;
    d = -1;
    if ($countones(b) == 1) begin
      for (int i = 0; i < N_BTN; i++) if (b[i]) d = i;
    end
    return d;
  endfunction

  task automatic model_step(input logic [3:0] b, input logic lr, input logic pen, input logic rn);
    int d;
    bit ok;
    err = 1'b0;
    d = btn_digit(b);
    if (!rn) begin
      mode = M_LOCKED; attempt.delete(); pbuf.delete();
      code = '{0, 1, 2, 3}; fails = 0; lock_left = 0; idle_cnt = 0;
    end else if (mode == M_LOCKED) begin
      if (b != 4'b0000) begin
        attempt.push_back(d);
        if (attempt.size() == CODE_LEN) begin
          ok = 1'b1;
          for (int i = 0; i < CODE_LEN; i++) if (attempt[i] != code[i]) ok = 1'b0;
          attempt.delete();
          if (ok) begin
            mode = M_UNLOCKED; fails = 0; idle_cnt = 0;
          end else begin
            err = 1'b1; fails++;
            if (fails >= MAX_FAIL) begin mode = M_LOCKOUT; lock_left = LOCKOUT; end
          end
        end
      end
    end else if (mode == M_LOCKOUT) begin
      lock_left--;
      if (lock_left == 0) begin mode = M_LOCKED; fails = 0; end
    end else if (mode == M_UNLOCKED) begin
      if (lr) begin
        mode = M_LOCKED; attempt.delete();
      end else if (pen) begin
        mode = M_PROGRAM; pbuf.delete();
      end else if (b != 4'b0000) begin
        idle_cnt = 0;
      end else begin
        idle_cnt++;
        if (idle_cnt == RELOCK) begin mode = M_LOCKED; attempt.delete(); end
      end
    end else begin
      if (!pen || (b != 4'b0000 && d < 0)) begin
        mode = M_UNLOCKED; err = 1'b1; pbuf.delete();
      end else if (d >= 0) begin
        pbuf.push_back(d);
        if (pbuf.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) code[i] = pbuf[i];
          pbuf.delete(); mode = M_UNLOCKED; idle_cnt = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int exp_entry;
    exp_entry = (mode == M_LOCKED) ? attempt.size() : (mode == M_PROGRAM) ? pbuf.size() : 0;
    chk("unlocked", int'(bus.unlocked), int'(mode == M_UNLOCKED || mode == M_PROGRAM));
    chk("locked_out", int'(bus.locked_out), int'(mode == M_LOCKOUT));
    chk("prog_active", int'(bus.prog_active), int'(mode == M_PROGRAM));
    chk("entry_cnt", int'(bus.entry_cnt), exp_entry);
    chk("fail_cnt", int'(bus.fail_cnt), fails);
    chk("err_pulse", int'(bus.err_pulse), int'(err));
  endtask

  task automatic tick(input logic [3:0] b, input logic lr = 1'b0, input logic rn = 1'b1);
    @(negedge clk);
    bus.btn_pulse = b;
    bus.lock_req  = lr;
    bus.prog_en   = pe;
    rst_n         = rn;
    @(posedge clk);
    model_step(b, lr, pe, rn);
    #1;
    compare_all();
  endtask

  task automatic press(input int d);
    tick(4'(1 << d));
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000);
  endtask

  initial begin
    int n;
    bus.btn_pulse = '0;
    bus.lock_req  = 1'b0;
    bus.prog_en   = 1'b0;

    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    chk("rst_unlocked", int'(bus.unlocked), 0);
    chk("rst_fail", int'(bus.fail_cnt), 0);
    chk("rst_entry", int'(bus.entry_cnt), 0);

    // correct default code
    press(0); press(1); press(2);
    chk("partial_entry", int'(bus.entry_cnt), 3);
    chk("partial_locked", int'(bus.unlocked), 0);
    press(3);
    chk("open_unlocked", int'(bus.unlocked), 1);
    chk("open_entry", int'(bus.entry_cnt), 0);
    tick(4'b0000, 1'b1);
    chk("lock_req", int'(bus.unlocked), 0);

    // three failures then lockout
    for (int k = 1; k <= MAX_FAIL; k++) begin
      enter(0, 1, 2, 2);
      chk("fail_err", int'(bus.err_pulse), 1);
      chk("fail_cnt_step", int'(bus.fail_cnt), k);
    end
    chk("lockout_on", int'(bus.locked_out), 1);
    chk("model_fails", fails, 3);
    n = 1;
    for (int i = 0; i < 100 && bus.locked_out; i++) begin
      tick(4'($urandom_range(1, 15)));
      if (bus.locked_out) n++;
    end
    chk("lockout_len", n, 16);
    chk("fail_after_lockout", int'(bus.fail_cnt), 0);

    // multi-press as second digit
    press(0); tick(4'b0011); press(2); press(3);
    chk("multi_err", int'(bus.err_pulse), 1);
    chk("multi_locked", int'(bus.unlocked), 0);

    // relock after idle
    enter(0, 1, 2, 3);
    idle(31);
    chk("relock_31", int'(bus.unlocked), 1);
    idle(1);
    chk("relock_32", int'(bus.unlocked), 0);

    // press keeps it open
    enter(0, 1, 2, 3);
    idle(19); press(1); idle(20);
    chk("relock_extend", int'(bus.unlocked), 1);
    tick(4'b0000, 1'b1);

    // reprogram to 3,3,1,0
    enter(0, 1, 2, 3);
    pe = 1'b1;
    tick(4'b0000);
    chk("prog_on", int'(bus.prog_active), 1);
    press(3); press(3); press(1); press(0);
    chk("prog_done", int'(bus.prog_active), 0);
    pe = 1'b0;
    tick(4'b0000, 1'b1);
    enter(3, 3, 1, 0);
    chk("new_code", int'(bus.unlocked), 1);
    tick(4'b0000, 1'b1);
    enter(0, 1, 2, 3);
    chk("old_code_err", int'(bus.err_pulse), 1);

    // abort program after two digits
    enter(3, 3, 1, 0);
    pe = 1'b1;
    tick(4'b0000); press(2); press(2);
    pe = 1'b0;
    tick(4'b0000);
    chk("abort_err", int'(bus.err_pulse), 1);
    chk("abort_unlocked", int'(bus.unlocked), 1);
    tick(4'b0000, 1'b1);
    enter(3, 3, 1, 0);
    chk("abort_keeps_code", int'(bus.unlocked), 1);

    // reset restores default code
    tick(4'b0000, 1'b0, 1'b0);
    enter(0, 1, 2, 3);
    chk("reset_default", int'(bus.unlocked), 1);

    // random phase
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] b;
      logic lr;
      logic rn;
      r = $urandom_range(0, 99);
      b = 4'b0000; lr = 1'b0; rn = 1'b1;
      if ($urandom_range(0, 49) == 0) pe = ~pe;
      if (r < 30) begin
        if (mode == M_LOCKED) b = 4'(1 << code[attempt.size()]);
        else b = 4'(1 << $urandom_range(0, 3));
      end else if (r < 45) begin
        b = 4'(1 << $urandom_range(0, 3));
      end else if (r < 48) begin
        b = 4'b1001;
      end else if (r < 51) begin
        lr = 1'b1;
      end else if (r == 51 && $urandom_range(0, 3) == 0) begin
        rn = 1'b0;
      end
      tick(b, lr, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
